// File: rtl/pmem_arbiter.sv
// N-channel arbiter that serialises cache line requests onto one pmem port.
// Define PMEM_ARB_RR_EN for round-robin; the default is fixed priority, where the lowest index wins.
module pmem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic                     pmem_resp,
  input  logic [LINE_W-1:0]        pmem_rdata
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [NUM_CH-1:0]   r_ch_resp;
  logic [LINE_W-1:0]   r_ch_rdata;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic [ADDR_W-1:0]   r_pmem_address;
  logic [LINE_W-1:0]   r_pmem_wdata;

  logic [NUM_CH-1:0]   w_req;
  logic [NUM_CH-1:0]   w_grant_oh;
  logic [IDX_W-1:0]    w_win;
  logic                w_found;

  assign w_req = ch_read | ch_write;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant_oh
    assign w_grant_oh[gi] = (r_grant == IDX_W'(gi));
  end

`ifdef PMEM_ARB_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W:0]   w_cand;
  logic [IDX_W-1:0] w_next_ptr;

  // Search starts at the pointer and wraps at NUM_CH, not at the next power of two.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_CH))
        w_cand = w_cand - (IDX_W+1)'(NUM_CH);
      if (!w_found && w_req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_next_ptr = (w_win == IDX_W'(NUM_CH-1)) ? '0 : w_win + IDX_W'(1);
`else
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && w_req[k]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_grant        <= '0;
      r_ch_resp      <= '0;
      r_ch_rdata     <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
`ifdef PMEM_ARB_RR_EN
      r_rr_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            // A write takes precedence when a channel raises read and write together.
            r_grant        <= w_win;
            r_pmem_write   <= ch_write[w_win];
            r_pmem_read    <= ~ch_write[w_win];
            r_pmem_address <= ch_address[w_win*ADDR_W +: ADDR_W];
            r_pmem_wdata   <= ch_wdata[w_win*LINE_W +: LINE_W];
            r_state        <= S_BUSY;
`ifdef PMEM_ARB_RR_EN
            r_rr_ptr       <= w_next_ptr;
`endif
          end
        end
        S_BUSY: begin
          if (pmem_resp) begin
            r_ch_rdata   <= pmem_rdata;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_ch_resp    <= w_grant_oh;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_ch_resp <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_resp      = r_ch_resp;
  assign ch_rdata     = r_ch_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
endmodule
